// File: rtl/data_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : data_bus_arbiter_if
// Description : Bundles the two requester ports and the shared memory bus
//               port of data_bus_arbiter.
//               Requester x (x = 0 core data port, x = 1 USB copy engine):
//                 reqx, addressx[31:0], write_valuex[31:0],
//                 write_sectionsx[3:0]                      requester -> arb
//                 grantx, read_validx, read_valuex[31:0]    arb -> requester
//               Shared bus:
//                 memory_address[31:0], memory_write_value[31:0],
//                 memory_write_sections[3:0]                arb -> memory
//                 memory_read_value[31:0]                   memory -> arb
//               modport slave  : arbiter view.
//               modport master : requester / memory side view.
// Revision    : 1.0 - initial release
// ============================================================================
interface data_bus_arbiter_if;
  logic        req0;
  logic [31:0] address0;
  logic [31:0] write_value0;
  logic [3:0]  write_sections0;
  logic        grant0;
  logic        read_valid0;
  logic [31:0] read_value0;

  logic        req1;
  logic [31:0] address1;
  logic [31:0] write_value1;
  logic [3:0]  write_sections1;
  logic        grant1;
  logic        read_valid1;
  logic [31:0] read_value1;

  logic [31:0] memory_address;
  logic [31:0] memory_write_value;
  logic [3:0]  memory_write_sections;
  logic [31:0] memory_read_value;

  modport slave (
    input  req0, address0, write_value0, write_sections0,
    output grant0, read_valid0, read_value0,
    input  req1, address1, write_value1, write_sections1,
    output grant1, read_valid1, read_value1,
    output memory_address, memory_write_value, memory_write_sections,
    input  memory_read_value
  );

  modport master (
    output req0, address0, write_value0, write_sections0,
    input  grant0, read_valid0, read_value0,
    output req1, address1, write_value1, write_sections1,
    input  grant1, read_valid1, read_value1,
    input  memory_address, memory_write_value, memory_write_sections,
    output memory_read_value
  );
endinterface
`default_nettype wire

// File: rtl/data_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : data_bus_arbiter
// Description : Round-robin arbiter with a burst cap that shares the single
//               block-RAM/MMIO data port between the core data port
//               (requester 0) and the USB buffer copy engine (requester 1).
// Ports       : clk24   - system clock
//               reset_n - asynchronous active-low reset
//               bus     - data_bus_arbiter_if.slave (requesters + memory bus)
// Parameters  : MAX_BURST - max consecutive contended grants per owner, 1..256
// Revision    : 1.0 - initial release
// ============================================================================
module data_bus_arbiter #(
  parameter int MAX_BURST = 16
) (
  input  wire logic          clk24,
  input  wire logic          reset_n,
  data_bus_arbiter_if.slave  bus
);

  localparam int BW = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          last_owner_q, last_owner_d;
  logic [BW-1:0] burst_count_q, burst_count_d;
  logic          read_valid0_q, read_valid0_d;
  logic          read_valid1_q, read_valid1_d;

  logic          grant0;
  logic          grant1;

  // Grants come straight from the state register, so an asynchronous reset
  // removes them (and any write enables) without waiting for a clock edge.
  assign grant0 = bus.req0 && (state_q == OWN0);
  assign grant1 = bus.req1 && (state_q == OWN1);

  assign bus.grant0 = grant0;
  assign bus.grant1 = grant1;

  // Zero the bus when nobody owns it so a write can never leak out ungranted.
  always_comb begin
    bus.memory_address        = 32'd0;
    bus.memory_write_value    = 32'd0;
    bus.memory_write_sections = 4'd0;
    if (grant0) begin
      bus.memory_address        = bus.address0;
      bus.memory_write_value    = bus.write_value0;
      bus.memory_write_sections = bus.write_sections0;
    end else if (grant1) begin
      bus.memory_address        = bus.address1;
      bus.memory_write_value    = bus.write_value1;
      bus.memory_write_sections = bus.write_sections1;
    end
  end

  // Read data is a pass-through; the per-requester valid flags qualify it.
  assign bus.read_value0 = bus.memory_read_value;
  assign bus.read_value1 = bus.memory_read_value;
  assign bus.read_valid0 = read_valid0_q;
  assign bus.read_valid1 = read_valid1_q;

  always_comb begin
    state_d       = state_q;
    last_owner_d  = last_owner_q;
    burst_count_d = burst_count_q;
    read_valid0_d = grant0 && (bus.write_sections0 == 4'd0);
    read_valid1_d = grant1 && (bus.write_sections1 == 4'd0);

    case (state_q)
      IDLE: begin
        // last_owner points at whoever was served most recently, so a tie
        // goes to the other requester.
        if (bus.req0 && bus.req1) begin
          state_d = last_owner_q ? OWN0 : OWN1;
        end else if (bus.req0) begin
          state_d = OWN0;
        end else if (bus.req1) begin
          state_d = OWN1;
        end
      end

      OWN0: begin
        if (!bus.req0) begin
          state_d       = bus.req1 ? OWN1 : IDLE;
          last_owner_d  = 1'b0;
          burst_count_d = '0;
        end else if (bus.req1) begin
          if (burst_count_q == BURST_LAST) begin
            state_d       = OWN1;
            last_owner_d  = 1'b0;
            burst_count_d = '0;
          end else begin
            burst_count_d = burst_count_q + 1'b1;
          end
        end else begin
          // Uncontended streaming does not consume burst budget.
          burst_count_d = '0;
        end
      end

      OWN1: begin
        if (!bus.req1) begin
          state_d       = bus.req0 ? OWN0 : IDLE;
          last_owner_d  = 1'b1;
          burst_count_d = '0;
        end else if (bus.req0) begin
          if (burst_count_q == BURST_LAST) begin
            state_d       = OWN0;
            last_owner_d  = 1'b1;
            burst_count_d = '0;
          end else begin
            burst_count_d = burst_count_q + 1'b1;
          end
        end else begin
          burst_count_d = '0;
        end
      end

      default: begin
        state_d       = IDLE;
        burst_count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      last_owner_q  <= 1'b1;
      burst_count_q <= '0;
      read_valid0_q <= 1'b0;
      read_valid1_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_owner_q  <= last_owner_d;
      burst_count_q <= burst_count_d;
      read_valid0_q <= read_valid0_d;
      read_valid1_q <= read_valid1_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_bus_arbiter
// Description : Directed self-checking bench for data_bus_arbiter with
//               MAX_BURST = 4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_bus_arbiter;

  logic clk24;
  logic reset_n;
  int   n_cmp;
  int   n_err;
  int   g0cnt;
  logic [11:0] pat;
  logic        exp_g0;
  logic        prev_g0;

  data_bus_arbiter_if bus_if ();

  data_bus_arbiter #(.MAX_BURST(4)) dut (
    .clk24   (clk24),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  initial clk24 = 1'b0;
  always #5 clk24 = ~clk24;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk24);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset_n = 1'b0;
    bus_if.req0 = 1'b1;
    bus_if.address0 = 32'h0000_0100;
    bus_if.write_value0 = 32'd0;
    bus_if.write_sections0 = 4'd0;
    bus_if.req1 = 1'b1;
    bus_if.address1 = 32'h0000_0200;
    bus_if.write_value1 = 32'd0;
    bus_if.write_sections1 = 4'd0;
    bus_if.memory_read_value = 32'hA5A5_0000;

    // Reset held with both requesting
    next_cycle();
    next_cycle();
    chk1("rst_grant0", bus_if.grant0, 1'b0);
    chk1("rst_grant1", bus_if.grant1, 1'b0);
    chk1("rst_rv0", bus_if.read_valid0, 1'b0);
    chk1("rst_rv1", bus_if.read_valid1, 1'b0);
    chk32("rst_maddr", bus_if.memory_address, 32'd0);
    chk32("rst_mws", {28'd0, bus_if.memory_write_sections}, 32'd0);

    // Release: one bubble, then requester 0 wins the tie; contended pattern
    next_cycle();
    reset_n = 1'b1;
    #1;
    chk1("rel_bubble_g0", bus_if.grant0, 1'b0);
    chk1("rel_bubble_g1", bus_if.grant1, 1'b0);

    pat = 12'b1111_0000_1111;
    prev_g0 = 1'b0;
    for (int c = 0; c < 12; c++) begin
      next_cycle();
      exp_g0 = pat[11 - c];
      chk1("burst_g0", bus_if.grant0, exp_g0);
      chk1("burst_g1", bus_if.grant1, ~exp_g0);
      chk32("burst_addr", bus_if.memory_address, exp_g0 ? 32'h0000_0100 : 32'h0000_0200);
      if (c > 0) begin
        chk1("burst_rv0", bus_if.read_valid0, prev_g0);
        chk1("burst_rv1", bus_if.read_valid1, ~prev_g0);
      end
      prev_g0 = exp_g0;
    end

    // Both drop: handover to OWN1 already happened, nothing granted
    next_cycle();
    bus_if.req0 = 1'b0;
    bus_if.req1 = 1'b0;
    #1;
    chk1("drop_g0", bus_if.grant0, 1'b0);
    chk1("drop_g1", bus_if.grant1, 1'b0);
    chk1("drop_rv0", bus_if.read_valid0, 1'b1);
    chk1("drop_rv1", bus_if.read_valid1, 1'b0);

    // Requester 1 read at 0x40 (state is IDLE now)
    next_cycle();
    bus_if.req1 = 1'b1;
    bus_if.address1 = 32'h0000_0040;
    #1;
    chk1("r1_bubble", bus_if.grant1, 1'b0);
    next_cycle();
    chk1("r1_grant", bus_if.grant1, 1'b1);
    chk32("r1_addr", bus_if.memory_address, 32'h0000_0040);
    chk32("r1_mws", {28'd0, bus_if.memory_write_sections}, 32'd0);
    next_cycle();
    bus_if.req1 = 1'b0;
    bus_if.memory_read_value = 32'hDEAD_BEEF;
    #1;
    chk1("r1_rv1", bus_if.read_valid1, 1'b1);
    chk32("r1_rdata", bus_if.read_value1, 32'hDEAD_BEEF);
    chk1("r1_rv0", bus_if.read_valid0, 1'b0);
    next_cycle();
    chk1("r1_rv1_once", bus_if.read_valid1, 1'b0);

    // Requester 0 write, then it drops while requester 1 waits
    bus_if.req0 = 1'b1;
    bus_if.address0 = 32'h8000_0010;
    bus_if.write_value0 = 32'h1234_5678;
    bus_if.write_sections0 = 4'b0011;
    #1;
    chk1("w_bubble", bus_if.grant0, 1'b0);
    next_cycle();
    bus_if.req1 = 1'b1;
    bus_if.address1 = 32'h0000_0044;
    #1;
    chk1("w_grant0", bus_if.grant0, 1'b1);
    chk1("w_grant1", bus_if.grant1, 1'b0);
    chk32("w_addr", bus_if.memory_address, 32'h8000_0010);
    chk32("w_wdata", bus_if.memory_write_value, 32'h1234_5678);
    chk32("w_mws", {28'd0, bus_if.memory_write_sections}, 32'h3);
    next_cycle();
    bus_if.req0 = 1'b0;
    #1;
    chk1("w_done_g0", bus_if.grant0, 1'b0);
    chk32("w_done_mws", {28'd0, bus_if.memory_write_sections}, 32'd0);
    chk1("w_no_rv0", bus_if.read_valid0, 1'b0);
    next_cycle();
    chk1("w_hand_g1", bus_if.grant1, 1'b1);
    chk32("w_hand_addr", bus_if.memory_address, 32'h0000_0044);
    chk1("w_no_rv0b", bus_if.read_valid0, 1'b0);
    next_cycle();
    bus_if.req1 = 1'b0;
    #1;
    chk1("w_r1_rv1", bus_if.read_valid1, 1'b1);
    chk1("w_r1_g1", bus_if.grant1, 1'b0);

    // Requester 0 alone for 40 cycles (state IDLE at the first one)
    next_cycle();
    bus_if.req0 = 1'b1;
    bus_if.address0 = 32'h0000_0010;
    bus_if.write_sections0 = 4'd0;
    g0cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (i != 0) next_cycle();
      else #1;
      if (bus_if.grant0) g0cnt++;
    end
    chk32("stream_g0cnt", 32'(g0cnt), 32'd39);

    // Contention after streaming: full budget of 4 remains, then handover
    next_cycle();
    bus_if.req1 = 1'b1;
    bus_if.address1 = 32'h0000_0300;
    bus_if.write_value1 = 32'hCAFE_F00D;
    bus_if.write_sections1 = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      if (k != 0) next_cycle();
      chk1("cont_g0", bus_if.grant0, (k < 4));
      chk1("cont_g1", bus_if.grant1, (k == 4));
    end
    chk32("own1_mws", {28'd0, bus_if.memory_write_sections}, 32'hF);

    // Asynchronous reset mid-burst
    #2;
    reset_n = 1'b0;
    #1;
    chk1("arst_g1", bus_if.grant1, 1'b0);
    chk1("arst_g0", bus_if.grant0, 1'b0);
    chk32("arst_mws", {28'd0, bus_if.memory_write_sections}, 32'd0);
    next_cycle();
    reset_n = 1'b1;
    #1;
    chk1("arel_bubble_g0", bus_if.grant0, 1'b0);
    chk1("arel_bubble_g1", bus_if.grant1, 1'b0);
    next_cycle();
    chk1("arel_tie_g0", bus_if.grant0, 1'b1);
    chk1("arel_tie_g1", bus_if.grant1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
